// File: rtl/eight_serial_comparator_pkg.sv
// Shared types and constants for the bit-serial MSB-first comparator.
// The state encoding and default width are defined here for reuse by the interface, top and bench.
package eight_cmp_pkg;

  localparam int CMP_WIDTH = 8;

  function automatic int cmp_idx_width(input int width);
    return $clog2(width);
  endfunction

  localparam int CMP_IDX_W = cmp_idx_width(CMP_WIDTH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPARE = 2'd1,
    DONE    = 2'd2
  } cmp_state_t;

endpackage

// File: rtl/eight_serial_comparator_if.sv
// Request/result bundle for the serial comparator.
// The master drives start and the operands; the slave returns status and the registered result.
interface eight_serial_comparator_if
  import eight_cmp_pkg::*;
#(
  parameter int WIDTH = CMP_WIDTH
);

  logic             start;
  logic [0:WIDTH-1] a;
  logic [0:WIDTH-1] b;
  logic             busy;
  logic             done;
  logic             e;
  logic             l;

  modport master (
    output start, a, b,
    input  busy, done, e, l
  );

  modport slave (
    input  start, a, b,
    output busy, done, e, l
  );

endinterface

// File: rtl/eight_serial_comparator_cmp_bit_cell.sv
// Single-bit magnitude cell: reports whether one bit pair is equal, or A's bit is below B's.
module cmp_bit_cell (
  input  logic a_bit,
  input  logic b_bit,
  output logic eq,
  output logic lt
);

  assign eq = ~(a_bit ^ b_bit);
  assign lt = ~a_bit & b_bit;

endmodule

// File: rtl/eight_serial_comparator.sv
// Bit-serial unsigned comparator: walks the captured operands MSB first, one bit per cycle,
// and stops at the first differing bit so that latency depends on where the operands diverge.
module eight_serial_comparator
  import eight_cmp_pkg::*;
#(
  parameter int WIDTH = CMP_WIDTH
)(
  input logic                    clk,
  input logic                    rst_n,
  eight_serial_comparator_if.slave bus
);

  localparam int IDX_W = (WIDTH == CMP_WIDTH) ? CMP_IDX_W : cmp_idx_width(WIDTH);

  cmp_state_t       state;
  cmp_state_t       state_nxt;
  logic [IDX_W-1:0] idx;
  logic [0:WIDTH-1] op_a;
  logic [0:WIDTH-1] op_b;
  logic             e_q;
  logic             l_q;
  logic             bit_eq;
  logic             bit_lt;
  logic             last_bit;

  assign last_bit = (idx == IDX_W'(WIDTH - 1));

  // Only the bit pair selected by the index is ever examined, so one cell suffices.
  cmp_bit_cell u_cell (
    .a_bit (op_a[idx]),
    .b_bit (op_b[idx]),
    .eq    (bit_eq),
    .lt    (bit_lt)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = COMPARE;
      COMPARE: if (!bit_eq || last_bit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
      op_a  <= '0;
      op_b  <= '0;
      e_q   <= 1'b0;
      l_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (bus.start) begin
            op_a <= bus.a;
            op_b <= bus.b;
            idx  <= '0;
          end
        end
        COMPARE: begin
          // The first differing bit decides the result outright; equality needs every bit.
          if (!bit_eq) begin
            e_q <= 1'b0;
            l_q <= bit_lt;
          end else if (last_bit) begin
            e_q <= 1'b1;
            l_q <= 1'b0;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = (state == COMPARE);
  assign bus.done = (state == DONE);
  assign bus.e    = e_q;
  assign bus.l    = l_q;

  a_result_exclusive: assert property (@(posedge clk) disable iff (!rst_n) !(e_q && l_q));
  a_done_single:      assert property (@(posedge clk) disable iff (!rst_n) bus.done |=> !bus.done);

endmodule
